// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: received-byte stream and status from the PS/2 keyboard receiver
interface ps2_kbd_rx_if #(
    parameter int FIFO_DEPTH = 8
);
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_ready;
    logic parity_err;
    logic frame_err;
    logic overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overflow, fifo_level,
        input  rx_ready
    );
    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overflow, fifo_level,
        output rx_ready
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard frame receiver with glitch filter, timeout and FWFT byte FIFO
module ps2_kbd_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic         clk,
    input  logic         N_RESET,
    input  logic         ps2Clk,
    input  logic         ps2Data,
    ps2_kbd_rx_if.master rx
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t state, state_n;
    logic ck_s1, ck_s2, dt_s1, dt_s2, ck_f;
    logic [FW-1:0] flt_cnt;
    logic strobe, tmo_hit, push, pop, full, push_ok, ovf;
    logic perr_n, ferr_n, perr_q, ferr_q, ovf_q;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic par_bit;
    logic [TW-1:0] tmo_cnt;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] level;

    // strobe is the cycle in which the filtered clock commits its 1->0 change
    assign strobe  = ck_f && !ck_s2 && flt_cnt == FW'(FILTER_LEN - 1);
    assign tmo_hit = state != IDLE && !strobe && tmo_cnt == TW'(TIMEOUT_CYC - 1);
    assign full    = level == (AW+1)'(FIFO_DEPTH);
    assign pop     = rx.rx_valid && rx.rx_ready;
    assign push_ok = push && (!full || pop);
    assign ovf     = push && full && !pop;

    assign rx.rx_valid   = |level;
    assign rx.rx_data    = rx.rx_valid ? mem[rp] : 8'h00;
    assign rx.fifo_level = level;
    assign rx.parity_err = perr_q;
    assign rx.frame_err  = ferr_q;
    assign rx.overflow   = ovf_q;

    // synchronize both lines and debounce the clock: level moves only after a full run of new samples
    always_ff @(posedge clk) begin
        if (!N_RESET) begin
            ck_s1   <= 1'b1;
            ck_s2   <= 1'b1;
            dt_s1   <= 1'b1;
            dt_s2   <= 1'b1;
            ck_f    <= 1'b1;
            flt_cnt <= '0;
        end else begin
            ck_s1 <= ps2Clk;
            ck_s2 <= ck_s1;
            dt_s1 <= ps2Data;
            dt_s2 <= dt_s1;
            if (ck_s2 == ck_f) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                ck_f    <= ck_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    // frame FSM next state and stop-bit verdict; timeout takes precedence over everything
    always_comb begin
        state_n = state;
        push    = 1'b0;
        perr_n  = 1'b0;
        ferr_n  = 1'b0;
        if (tmo_hit) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
        end else if (strobe) begin
            case (state)
                IDLE:   state_n = dt_s2 ? IDLE : DATA;
                DATA:   state_n = bit_cnt == 3'd7 ? PARITY : DATA;
                PARITY: state_n = STOP;
                STOP: begin
                    state_n = IDLE;
                    ferr_n  = !dt_s2;
                    perr_n  = dt_s2 && !(^{shreg, par_bit});
                    push    = dt_s2 && (^{shreg, par_bit});
                end
            endcase
        end
    end

    // FSM state, shift register, bit counter and timeout counter
    always_ff @(posedge clk) begin
        if (!N_RESET) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_n;
            tmo_cnt <= (state == IDLE || strobe || tmo_hit) ? '0 : tmo_cnt + TW'(1);
            if (strobe && state == IDLE)
                bit_cnt <= '0;
            if (strobe && state == DATA) begin
                shreg   <= {dt_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (strobe && state == PARITY)
                par_bit <= dt_s2;
        end
    end

    // registered one-cycle status pulses, mutually exclusive by construction
    always_ff @(posedge clk) begin
        if (!N_RESET) begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            perr_q <= perr_n;
            ferr_q <= ferr_n;
            ovf_q  <= ovf;
        end
    end

    // FIFO storage; a push while full is only accepted when the head leaves in the same cycle
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wp] <= shreg;
    end

    // FIFO pointers and occupancy, wrapping naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (!N_RESET) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            wp    <= wp + AW'(push_ok);
            rp    <= rp + AW'(pop);
            level <= level + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed self-checking bench for the PS/2 keyboard receiver
module tb_ps2_kbd_rx;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 300;
    localparam int FIFO_DEPTH  = 8;
    localparam int HALF        = 20;

    logic clk = 1'b0;
    logic N_RESET = 1'b0;
    logic ps2Clk = 1'b1;
    logic ps2Data = 1'b1;
    int total = 0;
    int bad = 0;
    int np = 0, nf = 0, no = 0, nm = 0;
    int s_p, s_f, s_o;
    logic v_pre, v_post;
    logic [7:0] d_post;
    logic [31:0] lv_pre, lv_post;

    ps2_kbd_rx_if #(.FIFO_DEPTH(FIFO_DEPTH)) rxi ();

    ps2_kbd_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .N_RESET(N_RESET),
        .ps2Clk(ps2Clk),
        .ps2Data(ps2Data),
        .rx(rxi)
    );

    always #5 clk = ~clk;

    // count status pulses in cycles, and cycles where more than one is high
    always @(negedge clk) begin
        if (rxi.parity_err) np++;
        if (rxi.frame_err) nf++;
        if (rxi.overflow) no++;
        if (int'(rxi.parity_err) + int'(rxi.frame_err) + int'(rxi.overflow) > 1) nm++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic odd(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic logic [10:0] mk(input logic [7:0] b, input logic p, input logic s);
        return {s, p, b, 1'b0};
    endfunction

    task automatic snap();
        s_p = np;
        s_f = nf;
        s_o = no;
    endtask

    task automatic ps2_bit(input logic b);
        ps2Data = b;
        repeat (HALF) @(negedge clk);
        ps2Clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2Clk = 1'b1;
    endtask

    task automatic send_range(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) ps2_bit(f[i]);
    endtask

    task automatic send_frame(input logic [10:0] f);
        send_range(f, 0, 10);
        ps2Data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_timed(input logic [10:0] f, input logic do_pop);
        send_range(f, 0, 9);
        ps2Data = f[10];
        repeat (HALF) @(negedge clk);
        ps2Clk = 1'b0;
        repeat (FILTER_LEN + 1) @(negedge clk);
        v_pre = rxi.rx_valid;
        lv_pre = 32'(rxi.fifo_level);
        rxi.rx_ready = do_pop;
        @(negedge clk);
        v_post = rxi.rx_valid;
        d_post = rxi.rx_data;
        lv_post = 32'(rxi.fifo_level);
        rxi.rx_ready = 1'b0;
        repeat (HALF - FILTER_LEN - 2) @(negedge clk);
        ps2Clk = 1'b1;
        ps2Data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pop1();
        rxi.rx_ready = 1'b1;
        @(negedge clk);
        rxi.rx_ready = 1'b0;
    endtask

    initial begin
        rxi.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rxi.rx_valid), 0);
        chk("rst_data", 32'(rxi.rx_data), 0);
        chk("rst_level", 32'(rxi.fifo_level), 0);
        chk("rst_perr", 32'(rxi.parity_err), 0);
        chk("rst_ferr", 32'(rxi.frame_err), 0);
        chk("rst_ovf", 32'(rxi.overflow), 0);
        N_RESET = 1'b1;
        repeat (5) @(negedge clk);

        snap();
        send_timed(mk(8'h1C, 1'b0, 1'b1), 1'b0);
        chk("lat_pre_valid", 32'(v_pre), 0);
        chk("lat_valid", 32'(v_post), 1);
        chk("lat_data", 32'(d_post), 32'h1C);
        chk("lat_level", lv_post, 1);
        chk("lat_perr", np - s_p, 0);
        chk("lat_ferr", nf - s_f, 0);
        chk("lat_ovf", no - s_o, 0);
        pop1();
        chk("pop_level", 32'(rxi.fifo_level), 0);
        chk("pop_valid", 32'(rxi.rx_valid), 0);

        snap();
        send_frame(mk(8'h1C, 1'b1, 1'b1));
        chk("par_perr", np - s_p, 1);
        chk("par_ferr", nf - s_f, 0);
        chk("par_level", 32'(rxi.fifo_level), 0);

        snap();
        send_frame(mk(8'h1C, 1'b0, 1'b0));
        chk("stop_ferr", nf - s_f, 1);
        chk("stop_perr", np - s_p, 0);
        chk("stop_level", 32'(rxi.fifo_level), 0);

        snap();
        send_range(mk(8'hA5, 1'b1, 1'b1), 0, 4);
        ps2Data = 1'b1;
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        chk("tmo_ferr", nf - s_f, 1);
        chk("tmo_level", 32'(rxi.fifo_level), 0);
        snap();
        send_frame(mk(8'hF0, 1'b1, 1'b1));
        chk("tmo_next_data", 32'(rxi.rx_data), 32'hF0);
        chk("tmo_next_level", 32'(rxi.fifo_level), 1);
        chk("tmo_next_err", (np - s_p) + (nf - s_f), 0);
        pop1();

        snap();
        send_range(mk(8'h3C, 1'b1, 1'b1), 0, 3);
        repeat (HALF / 2) @(negedge clk);
        ps2Clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2Clk = 1'b1;
        repeat (HALF) @(negedge clk);
        send_range(mk(8'h3C, 1'b1, 1'b1), 4, 10);
        ps2Data = 1'b1;
        repeat (HALF) @(negedge clk);
        chk("glitch_data", 32'(rxi.rx_data), 32'h3C);
        chk("glitch_level", 32'(rxi.fifo_level), 1);
        chk("glitch_err", (np - s_p) + (nf - s_f), 0);
        pop1();

        snap();
        for (int i = 1; i <= 9; i++) begin
            send_frame(mk(8'(i), odd(8'(i)), 1'b1));
            if (i == 8) begin
                chk("ovf8_level", 32'(rxi.fifo_level), 8);
                chk("ovf8_ovf", no - s_o, 0);
            end
        end
        chk("ovf9_ovf", no - s_o, 1);
        chk("ovf9_level", 32'(rxi.fifo_level), 8);
        rxi.rx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", 32'(rxi.rx_data), 32'(i));
            @(negedge clk);
        end
        chk("drain_empty", 32'(rxi.rx_valid), 0);
        rxi.rx_ready = 1'b0;

        for (int i = 8'h11; i <= 8'h18; i++) send_frame(mk(8'(i), odd(8'(i)), 1'b1));
        snap();
        send_timed(mk(8'h19, odd(8'h19), 1'b1), 1'b1);
        chk("fullpop_pre", lv_pre, 8);
        chk("fullpop_level", lv_post, 8);
        chk("fullpop_head", 32'(d_post), 32'h12);
        chk("fullpop_ovf", no - s_o, 0);
        rxi.rx_ready = 1'b1;
        for (int i = 8'h12; i <= 8'h19; i++) begin
            chk("fullpop_data", 32'(rxi.rx_data), 32'(i));
            @(negedge clk);
        end
        chk("fullpop_empty", 32'(rxi.rx_valid), 0);
        rxi.rx_ready = 1'b0;

        send_frame(mk(8'h33, odd(8'h33), 1'b1));
        chk("prerst_level", 32'(rxi.fifo_level), 1);
        snap();
        send_range(mk(8'h77, odd(8'h77), 1'b1), 0, 5);
        repeat (5) @(negedge clk);
        N_RESET = 1'b0;
        @(negedge clk);
        N_RESET = 1'b1;
        chk("mrst_valid", 32'(rxi.rx_valid), 0);
        chk("mrst_data", 32'(rxi.rx_data), 0);
        chk("mrst_level", 32'(rxi.fifo_level), 0);
        chk("mrst_pulses", 32'({rxi.parity_err, rxi.frame_err, rxi.overflow}), 0);
        ps2Data = 1'b1;
        repeat (HALF) @(negedge clk);
        send_frame(mk(8'h5A, 1'b1, 1'b1));
        chk("mrst_next_data", 32'(rxi.rx_data), 32'h5A);
        chk("mrst_next_level", 32'(rxi.fifo_level), 1);
        chk("mrst_err", (np - s_p) + (nf - s_f) + (no - s_o), 0);

        chk("multi_pulse", nm, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the ports SHALL be named clk and N_RESET.
REQ-002 Parameter FILTER_LEN, default 8: consecutive equal synchronized samples required before the filtered ps2Clk changes level.
REQ-003 Parameter TIMEOUT_CYC, default 100000: clk cycles without a falling edge of the filtered clock, mid-frame, before the frame is aborted.
REQ-004 Parameter FIFO_DEPTH, default 8: byte FIFO depth, power of two.
REQ-005 clk  in  1  system clock; all state updates on the rising edge.
REQ-006 N_RESET  in  1  synchronous active-low reset.
REQ-007 ps2Clk  in  1  asynchronous PS/2 clock; idles high.
REQ-008 ps2Data  in  1  asynchronous PS/2 data; idles high.
REQ-009 rx_data  out  8  FIFO head byte; valid only while rx_valid=1.
REQ-010 rx_valid  out  1  FIFO not empty.
REQ-011 rx_ready  in  1  consumer accepts the head byte when rx_valid=1 and rx_ready=1.
REQ-012 parity_err  out  1  one-cycle pulse: frame discarded for bad parity.
REQ-013 frame_err  out  1  one-cycle pulse: frame discarded for a bad stop bit or a timeout.
REQ-014 overflow  out  1  one-cycle pulse: valid frame dropped because the FIFO was full.
REQ-015 fifo_level  out  log2(FIFO_DEPTH)+1  number of bytes held.

Function
REQ-016 ps2Clk and ps2Data SHALL each pass through a two-flop synchronizer.
REQ-017 The filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples at the new level.
REQ-018 A sample strobe SHALL occur in the single cycle in which the filtered clock goes from 1 to 0; the synchronized ps2Data SHALL be sampled in that cycle.
REQ-019 FSM states SHALL be IDLE, DATA, PARITY and STOP.
REQ-020 IDLE: on a strobe with data=0 (start bit), the FSM SHALL go to DATA with bit count 0; on a strobe with data=1, it SHALL stay in IDLE.
REQ-021 DATA: each strobe SHALL shift in one bit LSB-first; after the 8th bit the FSM SHALL go to PARITY.
REQ-022 PARITY: the strobe SHALL capture the parity bit; odd parity SHALL be required, meaning the XOR of the 8 data bits and the parity bit equals 1.
REQ-023 STOP, on a strobe, the FSM SHALL return to IDLE and apply the first matching case:
- stop bit = 0: frame_err pulses, byte discarded.
- parity bad: parity_err pulses, byte discarded.
- otherwise: byte pushed to the FIFO.
REQ-024 Timeout: in a non-IDLE state, a counter SHALL clear on every strobe. If it reaches TIMEOUT_CYC, frame_err SHALL pulse and the FSM SHALL go to IDLE, discarding the partial frame.
REQ-025 FIFO SHALL be first-word-fall-through: rx_data shows the head, and a pop occurs on rx_valid and rx_ready.
REQ-026 Latency: a pushed byte SHALL appear with rx_valid=1 in the cycle after the stop-bit strobe.
REQ-027 Push while full with no pop in the same cycle: the new byte SHALL be dropped, overflow SHALL pulse, and FIFO contents SHALL be unchanged.
REQ-028 Push while full with a pop in the same cycle: the push SHALL be accepted, fifo_level SHALL stay FIFO_DEPTH, and overflow SHALL stay 0.
REQ-029 Simultaneous push and pop when not full: fifo_level SHALL be unchanged and order SHALL be preserved.
REQ-030 rx_ready while rx_valid=0 SHALL have no effect.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 At most one error pulse SHALL be asserted per cycle.

Reset
REQ-033 While N_RESET=0 at a clock edge, the block SHALL reset as follows:
- FSM: IDLE; bit count and timeout counter: 0.
- FIFO: empty, pointers 0.
- Filtered clock, synchronizers and filter state: 1.
- rx_data=0x00, rx_valid=0, parity_err=0, frame_err=0, overflow=0, fifo_level=0.
REQ-034 Reset mid-frame SHALL discard the partial frame without any error pulse; reception SHALL restart with the next start bit.

Verification
REQ-035 Send frame 0x1C, parity 0, stop 1, rx_ready=0 -> cycle after the stop strobe: rx_valid=1, rx_data=0x1C, fifo_level=1, no error pulses.
REQ-036 Send 0x1C with parity 1 -> parity_err single pulse, fifo_level stays 0. Send 0x1C with stop 0 -> frame_err single pulse, no push.
REQ-037 Send start bit plus 4 data bits, then hold ps2Clk high for TIMEOUT_CYC+10 cycles -> frame_err single pulse, FSM in IDLE. A following frame 0xF0 (parity 1) -> rx_data=0xF0.
REQ-038 rx_ready=0; send 9 valid frames 0x01..0x09 -> fifo_level=8, overflow pulses on the 9th frame only. Then rx_ready=1 -> bytes read out in order 0x01..0x08, rx_valid falls after 0x08.
REQ-039 Inject a ps2Clk low glitch of FILTER_LEN-1 cycles during DATA -> no bit shifted; the frame still decodes correctly.
REQ-040 N_RESET=0 for 1 cycle after 5 data bits -> all outputs 0 next cycle, no error pulse; the next full frame 0x5A (parity 1) is received correctly.
